// File: rtl/scan_pkg.sv
// Shared definitions for the scan-driven AHB-Lite single-transfer master.
// Holds the FSM state type, AHB encodings and the status codes reported
// back to the scan front end.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_OK   = 2'b10;
  localparam logic [1:0] ST_ERR  = 2'b11;

  // Word transfers only: the two low address bits must be zero.
  function automatic logic word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/scan_ahb_wdog.sv
// Ready-timeout watchdog for the scan AHB master.
// Counts consecutive stalled bus cycles and flags the cycle whose stall
// would bring the count to TIMEOUT, so the FSM can abort on that edge.
//   clk    : system clock
//   rst    : synchronous active-high reset
//   clear  : restart the count (new transfer, or slave signalled ready)
//   enable : a stalled bus cycle (busy and hready low)
//   expire : this stalled cycle is the TIMEOUT-th in a row
module scan_ahb_wdog #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Saturates at TIMEOUT instead of wrapping; the FSM is idle by then.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = enable && (count == CNT_LAST);

endmodule

// File: rtl/scan_ahb_master.sv
// Single-transfer AHB-Lite master driven by the scan-chain front end.
// One start pulse runs one word read or write; results, status and a
// one-cycle done pulse are returned. A watchdog aborts dead transfers.
//   clk, rst             : clock / synchronous active-high reset
//   sm_start_scan        : one-cycle command start
//   addr_scan, wrdata_scan, we_scan : command address, write data, direction
//   rddata_scan          : last successful read data
//   hmsel_scan           : status 00 idle, 01 busy, 10 ok, 11 error
//   ahberr_scan          : error flag of the last command
//   done                 : one-cycle completion pulse
//   haddr..hwdata        : AHB-Lite master outputs
//   hrdata, hready, hresp: AHB-Lite slave response
//
// state | meaning
// IDLE  | no transfer; accept a start, report misaligned commands
// ADDR  | address phase, htrans=NONSEQ until hready
// DATA  | data phase, collect hresp until hready
module scan_ahb_master
  import scan_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sm_start_scan,
  input  logic [31:0] addr_scan,
  input  logic [31:0] wrdata_scan,
  input  logic        we_scan,
  output logic [31:0] rddata_scan,
  output logic [1:0]  hmsel_scan,
  output logic        ahberr_scan,
  output logic        done,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  state_t state, state_nxt;

  logic        start, start_ok, start_bad, busy;
  logic        wd_clear, wd_enable, wd_expire;
  logic        err, err_nxt, err_cur;
  logic [1:0]  htrans_nxt, hmsel_nxt;
  logic        ahberr_nxt, done_nxt, hwrite_nxt;
  logic [31:0] rddata_nxt, haddr_nxt, hwdata_nxt;

  assign start     = (state == IDLE) && sm_start_scan;
  assign start_ok  = start && word_aligned(addr_scan[1:0]);
  assign start_bad = start && !word_aligned(addr_scan[1:0]);
  assign busy      = (state != IDLE);
  assign err_cur   = err | hresp;

  assign wd_clear  = start_ok || (busy && hready);
  assign wd_enable = busy && !hready;

  assign hsize  = HSIZE_WORD;
  assign hburst = HBURST_SINGLE;

  scan_ahb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_ok) state_nxt = ADDR;
      ADDR: begin
        if (hready)         state_nxt = DATA;
        else if (wd_expire) state_nxt = IDLE;
      end
      DATA: begin
        if (hready || wd_expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output; all outputs leave flops.
  always_comb begin
    htrans_nxt = HTRANS_IDLE;
    hmsel_nxt  = hmsel_scan;
    ahberr_nxt = ahberr_scan;
    done_nxt   = 1'b0;
    rddata_nxt = rddata_scan;
    haddr_nxt  = haddr;
    hwrite_nxt = hwrite;
    hwdata_nxt = hwdata;
    err_nxt    = err;
    case (state)
      IDLE: begin
        if (start) begin
          haddr_nxt  = addr_scan;
          hwdata_nxt = wrdata_scan;
          hwrite_nxt = we_scan;
        end
        if (start_bad) begin
          hmsel_nxt  = ST_ERR;
          ahberr_nxt = 1'b1;
          done_nxt   = 1'b1;
        end else if (start_ok) begin
          htrans_nxt = HTRANS_NONSEQ;
          hmsel_nxt  = ST_BUSY;
          ahberr_nxt = 1'b0;
          err_nxt    = 1'b0;
        end
      end
      ADDR: begin
        if (hready) begin
          htrans_nxt = HTRANS_IDLE;
        end else if (wd_expire) begin
          hmsel_nxt  = ST_ERR;
          ahberr_nxt = 1'b1;
          done_nxt   = 1'b1;
        end else begin
          htrans_nxt = HTRANS_NONSEQ;
        end
      end
      DATA: begin
        err_nxt = err_cur;
        if (hready) begin
          hmsel_nxt  = err_cur ? ST_ERR : ST_OK;
          ahberr_nxt = err_cur;
          done_nxt   = 1'b1;
          if (!hwrite && !err_cur) rddata_nxt = hrdata;
        end else if (wd_expire) begin
          hmsel_nxt  = ST_ERR;
          ahberr_nxt = 1'b1;
          done_nxt   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      htrans      <= HTRANS_IDLE;
      hmsel_scan  <= ST_IDLE;
      ahberr_scan <= 1'b0;
      done        <= 1'b0;
      rddata_scan <= '0;
      haddr       <= '0;
      hwrite      <= 1'b0;
      hwdata      <= '0;
      err         <= 1'b0;
    end else begin
      htrans      <= htrans_nxt;
      hmsel_scan  <= hmsel_nxt;
      ahberr_scan <= ahberr_nxt;
      done        <= done_nxt;
      rddata_scan <= rddata_nxt;
      haddr       <= haddr_nxt;
      hwrite      <= hwrite_nxt;
      hwdata      <= hwdata_nxt;
      err         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_scan_ahb_master.sv
module tb_scan_ahb_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        sm_start_scan;
  logic [31:0] addr_scan;
  logic [31:0] wrdata_scan;
  logic        we_scan;
  logic [31:0] rddata_scan;
  logic [1:0]  hmsel_scan;
  logic        ahberr_scan;
  logic        done;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  scan_ahb_master #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .sm_start_scan (sm_start_scan),
    .addr_scan     (addr_scan),
    .wrdata_scan   (wrdata_scan),
    .we_scan       (we_scan),
    .rddata_scan   (rddata_scan),
    .hmsel_scan    (hmsel_scan),
    .ahberr_scan   (ahberr_scan),
    .done          (done),
    .haddr         (haddr),
    .htrans        (htrans),
    .hwrite        (hwrite),
    .hsize         (hsize),
    .hburst        (hburst),
    .hwdata        (hwdata),
    .hrdata        (hrdata),
    .hready        (hready),
    .hresp         (hresp)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passes = 0;

  // Reference model: results the scan side should currently be holding.
  logic [31:0] exp_rddata;
  logic [1:0]  exp_hmsel;
  logic        exp_ahberr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_htrans"}, 32'(htrans), 32'd0);
    chk({pfx, "_haddr"},  haddr, 32'd0);
    chk({pfx, "_hwrite"}, 32'(hwrite), 32'd0);
    chk({pfx, "_hwdata"}, hwdata, 32'd0);
    chk({pfx, "_rddata"}, rddata_scan, 32'd0);
    chk({pfx, "_hmsel"},  32'(hmsel_scan), 32'd0);
    chk({pfx, "_ahberr"}, 32'(ahberr_scan), 32'd0);
    chk({pfx, "_done"},   32'(done), 32'd0);
    chk({pfx, "_hsize"},  32'(hsize), 32'd2);
    chk({pfx, "_hburst"}, 32'(hburst), 32'd0);
  endtask

  // One command. Slave: aw stalled address-phase cycles, then dw stalled
  // data-phase cycles, hresp=er throughout the data phase, hrdata=rd.
  // ign injects a second start while the command is in flight.
  task automatic run_cmd(input logic [31:0] a, input logic [31:0] wd, input logic w,
                         input int aw, input int dw, input logic er,
                         input logic [31:0] rd, input logic ign);
    int          done_at;
    int          ns_last;
    int          idx;
    logic [1:0]  st;
    logic        ae;
    logic        upd;
    upd = 1'b0;
    if (a[1:0] != 2'b00) begin
      done_at = 1;          ns_last = 0;      st = 2'b11; ae = 1'b1;
    end else if (aw >= TO) begin
      done_at = TO + 1;     ns_last = TO;     st = 2'b11; ae = 1'b1;
    end else if (dw >= TO) begin
      done_at = aw + 2 + TO; ns_last = aw + 1; st = 2'b11; ae = 1'b1;
    end else begin
      done_at = aw + dw + 3; ns_last = aw + 1;
      st  = er ? 2'b11 : 2'b10;
      ae  = er;
      upd = !w && !er;
    end

    sm_start_scan = 1'b1;
    addr_scan     = a;
    wrdata_scan   = wd;
    we_scan       = w;
    hready        = 1'b1;
    hresp         = 1'b0;
    hrdata        = rd;

    for (int k = 1; k <= done_at; k++) begin
      tick();
      sm_start_scan = 1'b0;
      addr_scan     = $urandom;
      wrdata_scan   = $urandom;
      we_scan       = 1'($urandom_range(0, 1));
      if (ign && k == 2) sm_start_scan = 1'b1;

      chk("done", 32'(done), 32'(k == done_at));
      chk("htrans", 32'(htrans), (k <= ns_last) ? 32'd2 : 32'd0);
      chk("haddr", haddr, a);
      chk("hwrite", 32'(hwrite), 32'(w));
      chk("hwdata", hwdata, wd);
      if (k < done_at) begin
        chk("hmsel_busy", 32'(hmsel_scan), 32'd1);
        chk("rddata_hold", rddata_scan, exp_rddata);
      end else begin
        exp_hmsel  = st;
        exp_ahberr = ae;
        if (upd) exp_rddata = rd;
        chk("hmsel_final", 32'(hmsel_scan), 32'(exp_hmsel));
        chk("ahberr_final", 32'(ahberr_scan), 32'(exp_ahberr));
        chk("rddata_final", rddata_scan, exp_rddata);
      end

      if (k <= aw) begin
        hready = 1'b0;
        hresp  = 1'b0;
      end else if (k == aw + 1) begin
        hready = 1'b1;
        hresp  = 1'b0;
      end else begin
        idx    = k - aw - 2;
        hready = (idx >= dw);
        hresp  = er;
      end
      hrdata = rd;
    end

    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = $urandom;
    tick();
    chk("done_idle", 32'(done), 32'd0);
    chk("htrans_idle", 32'(htrans), 32'd0);
    chk("hmsel_hold", 32'(hmsel_scan), 32'(exp_hmsel));
    chk("ahberr_hold", 32'(ahberr_scan), 32'(exp_ahberr));
    chk("rddata_hold_idle", rddata_scan, exp_rddata);
  endtask

  initial begin
    #500000;
    $display("FAIL global_guard: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] ra;
    int          raw, rdw;
    rst           = 1'b1;
    sm_start_scan = 1'b0;
    addr_scan     = '0;
    wrdata_scan   = '0;
    we_scan       = 1'b0;
    hrdata        = '0;
    hready        = 1'b1;
    hresp         = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    rst        = 1'b0;
    exp_rddata = '0;
    exp_hmsel  = 2'b00;
    exp_ahberr = 1'b0;
    tick();

    // Zero-wait read
    run_cmd(32'h1000_0040, 32'h0, 1'b0, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
    // Write with three data-phase wait states
    run_cmd(32'h2000_0000, 32'h1234_5678, 1'b1, 0, 3, 1'b0, 32'h1111_2222, 1'b0);
    // Two-cycle ERROR response on a read
    run_cmd(32'h3000_0010, 32'h0, 1'b0, 0, 1, 1'b1, 32'hCAFE_F00D, 1'b0);
    // Misaligned
    run_cmd(32'h0000_0002, 32'hAAAA_5555, 1'b0, 0, 0, 1'b0, 32'h3333_4444, 1'b0);
    // Dead slave in address phase, second start ignored
    run_cmd(32'h4000_0000, 32'h0, 1'b0, TO + 3, 0, 1'b0, 32'h5555_6666, 1'b1);
    // Normal read after abort
    run_cmd(32'h4000_0004, 32'h0, 1'b0, 0, 0, 1'b0, 32'h55AA_33CC, 1'b0);
    // Watchdog boundaries: TIMEOUT-1 stalls survive, TIMEOUT stalls abort
    run_cmd(32'h5000_0008, 32'h0, 1'b0, 0, TO - 1, 1'b0, 32'h0F0F_0F0F, 1'b0);
    run_cmd(32'h5000_000C, 32'h0, 1'b0, TO - 1, 0, 1'b0, 32'h7070_7070, 1'b0);
    run_cmd(32'h6000_0000, 32'h9999_8888, 1'b1, 1, TO, 1'b0, 32'h0, 1'b1);
    run_cmd(32'h6000_0010, 32'h0, 1'b0, 2, TO, 1'b1, 32'hABAB_CDCD, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = $urandom;
      if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
      raw = $urandom_range(0, 3);
      rdw = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) raw = TO + 1;
      else if ($urandom_range(0, 9) == 0) rdw = TO + $urandom_range(0, 1);
      run_cmd(ra, $urandom, 1'($urandom_range(0, 1)), raw, rdw,
              1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset while in the data phase
    sm_start_scan = 1'b1;
    addr_scan     = 32'h7000_0000;
    we_scan       = 1'b0;
    wrdata_scan   = 32'h2468_ACE0;
    hready        = 1'b1;
    hresp         = 1'b0;
    hrdata        = 32'h0BAD_F00D;
    tick();
    sm_start_scan = 1'b0;
    chk("rst_seq_nonseq", 32'(htrans), 32'd2);
    tick();
    chk("rst_seq_data", 32'(htrans), 32'd0);
    rst = 1'b1;
    tick();
    check_reset_values("midreset");
    rst        = 1'b0;
    exp_rddata = '0;
    exp_hmsel  = 2'b00;
    exp_ahberr = 1'b0;
    tick();
    chk("post_reset_done", 32'(done), 32'd0);
    run_cmd(32'h7000_0004, 32'h0, 1'b0, 1, 1, 1'b0, 32'hFACE_B00C, 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
